// File: rtl/layer_compositor.sv
// Two-stage N-layer priority pixel compositor with colour-key transparency,
// border override, background fill and a frame-timed blinking hit-flash.
module layer_compositor #(
    parameter int unsigned          NUM_LAYERS   = 6,
    parameter int unsigned          PIXEL_W      = 24,
    parameter logic [PIXEL_W-1:0]   KEY_COLOR    = 24'h0,
    parameter logic [PIXEL_W-1:0]   BORDER_COLOR = 24'hFFFFFF,
    parameter logic [PIXEL_W-1:0]   FLASH_COLOR  = 24'hFF0000,
    parameter int unsigned          FLASH_FRAMES = 30,
    parameter int unsigned          BLINK_FRAMES = 4,
    localparam int unsigned         LID_W        = $clog2(NUM_LAYERS + 2)
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_LAYERS*PIXEL_W-1:0] layers_in,
    input  logic [NUM_LAYERS-1:0]         layer_en_in,
    input  logic                          border_in,
    input  logic [PIXEL_W-1:0]            bg_color_in,
    input  logic                          active_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          new_frame_in,
    input  logic                          flash_start_in,
    input  logic [LID_W-1:0]              flash_layer_in,
    output logic [PIXEL_W-1:0]            pixel_out,
    output logic [LID_W-1:0]              layer_id_out,
    output logic                          active_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          flashing_out
);

    localparam int unsigned FR_W = $clog2(FLASH_FRAMES + 1);
    localparam int unsigned BL_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {StIdle, StFlash} state_e;

    // Stage 1 registers
    logic [NUM_LAYERS*PIXEL_W-1:0] s1_layers_q;
    logic [NUM_LAYERS-1:0]         s1_opaque_q, s1_opaque_d;
    logic                          s1_border_q;
    logic [PIXEL_W-1:0]            s1_bg_q;
    logic                          s1_active_q, s1_hsync_q, s1_vsync_q;

    // Stage 2 registers
    logic [PIXEL_W-1:0]            s2_pixel_q, s2_pixel_d;
    logic [LID_W-1:0]              s2_id_q, s2_id_d;
    logic                          s2_active_q, s2_hsync_q, s2_vsync_q;

    // Flash FSM registers
    state_e                        state_q, state_d;
    logic [FR_W-1:0]               frames_left_q, frames_left_d;
    logic [BL_W-1:0]               blink_q, blink_d;
    logic                          flash_on_q, flash_on_d;
    logic [LID_W-1:0]              flash_layer_q, flash_layer_d;

    logic                          win_any;
    logic [LID_W-1:0]              win_idx;
    logic [PIXEL_W-1:0]            win_pix;

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            s1_opaque_d[i] = layer_en_in[i] && (layers_in[i*PIXEL_W +: PIXEL_W] != KEY_COLOR);
        end
    end

    // Descending scan so the lowest opaque index is the last (winning) assignment.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_pix = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_opaque_q[i]) begin
                win_any = 1'b1;
                win_idx = LID_W'(i);
                win_pix = s1_layers_q[i*PIXEL_W +: PIXEL_W];
            end
        end
    end

    always_comb begin
        s2_pixel_d = bg_color_zero();
        s2_id_d    = LID_W'(NUM_LAYERS + 1);
        if (!s1_active_q) begin
            s2_pixel_d = '0;
            s2_id_d    = LID_W'(NUM_LAYERS + 1);
        end else if (s1_border_q) begin
            s2_pixel_d = BORDER_COLOR;
            s2_id_d    = LID_W'(NUM_LAYERS);
        end else if (win_any) begin
            s2_pixel_d = (flash_on_q && (win_idx == flash_layer_q)) ? FLASH_COLOR : win_pix;
            s2_id_d    = win_idx;
        end else begin
            s2_pixel_d = s1_bg_q;
            s2_id_d    = LID_W'(NUM_LAYERS + 1);
        end
    end

    function automatic logic [PIXEL_W-1:0] bg_color_zero();
        return '0;
    endfunction

    // A start pulse pre-empts any frame pulse in the same cycle.
    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        blink_d       = blink_q;
        flash_on_d    = flash_on_q;
        flash_layer_d = flash_layer_q;
        if (flash_start_in && (flash_layer_in < LID_W'(NUM_LAYERS))) begin
            state_d       = StFlash;
            frames_left_d = FR_W'(FLASH_FRAMES);
            blink_d       = '0;
            flash_on_d    = 1'b1;
            flash_layer_d = flash_layer_in;
        end else if ((state_q == StFlash) && new_frame_in) begin
            frames_left_d = frames_left_q - FR_W'(1);
            if (blink_q == BL_W'(BLINK_FRAMES - 1)) begin
                blink_d    = '0;
                flash_on_d = !flash_on_q;
            end else begin
                blink_d = blink_q + BL_W'(1);
            end
            if (frames_left_q == FR_W'(1)) begin
                state_d    = StIdle;
                flash_on_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_layers_q   <= '0;
            s1_opaque_q   <= '0;
            s1_border_q   <= 1'b0;
            s1_bg_q       <= '0;
            s1_active_q   <= 1'b0;
            s1_hsync_q    <= 1'b0;
            s1_vsync_q    <= 1'b0;
            s2_pixel_q    <= '0;
            s2_id_q       <= '0;
            s2_active_q   <= 1'b0;
            s2_hsync_q    <= 1'b0;
            s2_vsync_q    <= 1'b0;
            state_q       <= StIdle;
            frames_left_q <= '0;
            blink_q       <= '0;
            flash_on_q    <= 1'b0;
            flash_layer_q <= '0;
        end else begin
            s1_layers_q   <= layers_in;
            s1_opaque_q   <= s1_opaque_d;
            s1_border_q   <= border_in;
            s1_bg_q       <= bg_color_in;
            s1_active_q   <= active_in;
            s1_hsync_q    <= hsync_in;
            s1_vsync_q    <= vsync_in;
            s2_pixel_q    <= s2_pixel_d;
            s2_id_q       <= s2_id_d;
            s2_active_q   <= s1_active_q;
            s2_hsync_q    <= s1_hsync_q;
            s2_vsync_q    <= s1_vsync_q;
            state_q       <= state_d;
            frames_left_q <= frames_left_d;
            blink_q       <= blink_d;
            flash_on_q    <= flash_on_d;
            flash_layer_q <= flash_layer_d;
        end
    end

    assign pixel_out    = s2_pixel_q;
    assign layer_id_out = s2_id_q;
    assign active_out   = s2_active_q;
    assign hsync_out    = s2_hsync_q;
    assign vsync_out    = s2_vsync_q;
    assign flashing_out = (state_q == StFlash);

endmodule

// File: tb/tb_layer_compositor.sv
// Randomized and directed bench for layer_compositor, checked against a
// behavioural compositor/flash model kept in the bench.
module tb_layer_compositor;

    localparam int N  = 6;
    localparam int PW = 24;
    localparam int LW = 3;
    localparam int FF = 30;
    localparam int BF = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*PW-1:0] t_layers = '0;
    logic [N-1:0]    t_en = '0;
    logic            t_border = 1'b0;
    logic [PW-1:0]   t_bg = '0;
    logic            t_active = 1'b0;
    logic            t_hsync = 1'b0;
    logic            t_vsync = 1'b0;
    logic            t_nf = 1'b0;
    logic            t_start = 1'b0;
    logic [LW-1:0]   t_flayer = '0;

    logic [PW-1:0]   pixel_out;
    logic [LW-1:0]   layer_id_out;
    logic            active_out, hsync_out, vsync_out, flashing_out;

    layer_compositor dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .layers_in      (t_layers),
        .layer_en_in    (t_en),
        .border_in      (t_border),
        .bg_color_in    (t_bg),
        .active_in      (t_active),
        .hsync_in       (t_hsync),
        .vsync_in       (t_vsync),
        .new_frame_in   (t_nf),
        .flash_start_in (t_start),
        .flash_layer_in (t_flayer),
        .pixel_out      (pixel_out),
        .layer_id_out   (layer_id_out),
        .active_out     (active_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .flashing_out   (flashing_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] pix;
        logic [LW-1:0] id;
        logic          act;
        logic          hs;
        logic          vs;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Flash model state
    bit   m_flashing;
    int   m_frames;
    int   m_blink;
    bit   m_on;
    int   m_layer;
    bit   prev_flashing;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flashing = 0; m_frames = 0; m_blink = 0; m_on = 0; m_layer = 0;
        prev_flashing = 0;
    endtask

    task automatic model_update();
        if (t_start && int'(t_flayer) < N) begin
            m_flashing = 1; m_frames = FF; m_blink = 0; m_on = 1; m_layer = int'(t_flayer);
        end else if (m_flashing && t_nf) begin
            m_frames--;
            m_blink++;
            if (m_blink == BF) begin
                m_blink = 0;
                m_on = !m_on;
            end
            if (m_frames == 0) begin
                m_flashing = 0;
                m_on = 0;
            end
        end
    endtask

    function automatic exp_t compose();
        exp_t e;
        int   idx;
        e.act = t_active; e.hs = t_hsync; e.vs = t_vsync;
        idx = -1;
        if (!t_active) begin
            e.pix = '0; e.id = LW'(N + 1);
        end else if (t_border) begin
            e.pix = 24'hFFFFFF; e.id = LW'(N);
        end else begin
            for (int i = 0; i < N; i++)
                if (idx < 0 && t_en[i] && t_layers[i*PW +: PW] != 24'h0) idx = i;
            if (idx >= 0) begin
                e.pix = (m_on && idx == m_layer) ? 24'hFF0000 : t_layers[idx*PW +: PW];
                e.id  = LW'(idx);
            end else begin
                e.pix = t_bg; e.id = LW'(N + 1);
            end
        end
        return e;
    endfunction

    // Check outputs, advance model with the applied inputs, clock once.
    task automatic step();
        exp_t o, e;
        if (exp_q.size() == 2) begin
            o = exp_q.pop_front();
            check_eq("pixel",  32'(pixel_out),    32'(o.pix));
            check_eq("id",     32'(layer_id_out), 32'(o.id));
            check_eq("active", 32'(active_out),   32'(o.act));
            check_eq("hsync",  32'(hsync_out),    32'(o.hs));
            check_eq("vsync",  32'(vsync_out),    32'(o.vs));
        end
        check_eq("flashing", 32'(flashing_out), 32'(prev_flashing));
        model_update();
        e = compose();
        exp_q.push_back(e);
        prev_flashing = m_flashing;
        @(negedge clk);
    endtask

    task automatic do_reset();
        exp_t z;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_pixel",  32'(pixel_out),    0);
        check_eq("rst_id",     32'(layer_id_out), 0);
        check_eq("rst_active", 32'(active_out),   0);
        check_eq("rst_hsync",  32'(hsync_out),    0);
        check_eq("rst_vsync",  32'(vsync_out),    0);
        check_eq("rst_flash",  32'(flashing_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        z.pix = '0; z.id = '0; z.act = 0; z.hs = 0; z.vs = 0;
        exp_q.push_back(z);
        z.id = LW'(N + 1);
        exp_q.push_back(z);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            t_nf = 1'b1; step();
            t_nf = 1'b0; step(); step();
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++)
            t_layers[i*PW +: PW] = ($urandom_range(0, 2) == 0) ? 24'h0 : PW'($urandom);
        t_en     = N'($urandom);
        t_border = ($urandom_range(0, 7) == 0);
        t_bg     = PW'($urandom);
        t_active = ($urandom_range(0, 7) != 0);
        t_hsync  = 1'($urandom);
        t_vsync  = 1'($urandom);
        t_nf     = ($urandom_range(0, 5) == 0);
        t_start  = ($urandom_range(0, 399) == 0);
        t_flayer = LW'($urandom);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Priority among opaque layers and per-layer enable
        t_active = 1; t_en = '1;
        t_layers[1*PW +: PW] = 24'h00FF00;
        t_layers[3*PW +: PW] = 24'h0000FF;
        step(); step();
        check_eq("prio_pix", 32'(pixel_out), 32'h00FF00);
        check_eq("prio_id", 32'(layer_id_out), 1);
        t_en[1] = 0;
        step(); step();
        check_eq("en_pix", 32'(pixel_out), 32'h0000FF);
        check_eq("en_id", 32'(layer_id_out), 3);

        // Border, background, inactive
        t_en = '1; t_layers[0 +: PW] = 24'hABCDEF; t_border = 1;
        step(); step();
        check_eq("border_pix", 32'(pixel_out), 32'hFFFFFF);
        check_eq("border_id", 32'(layer_id_out), 6);
        t_border = 0; t_layers = '0; t_bg = 24'h123456;
        step(); step();
        check_eq("bg_pix", 32'(pixel_out), 32'h123456);
        check_eq("bg_id", 32'(layer_id_out), 7);
        t_active = 0;
        step(); step();
        check_eq("inact_pix", 32'(pixel_out), 0);
        check_eq("inact_id", 32'(layer_id_out), 7);

        // Flash layer 2 for a full run
        t_active = 1;
        t_layers[2*PW +: PW] = 24'h112233;
        t_layers[5*PW +: PW] = 24'h445566;
        t_start = 1; t_flayer = 3'd2; step(); t_start = 0;
        step();
        check_eq("flash_on_pix", 32'(pixel_out), 32'hFF0000);
        frames(29);
        check_eq("flash_29", 32'(flashing_out), 1);
        frames(1);
        check_eq("flash_30", 32'(flashing_out), 0);
        step(); step();
        check_eq("flash_done_pix", 32'(pixel_out), 32'h112233);

        // Restart mid-flash on layer 5
        t_start = 1; t_flayer = 3'd2; step(); t_start = 0;
        frames(10);
        t_en[2] = 0;
        t_start = 1; t_flayer = 3'd5; step(); t_start = 0;
        frames(29);
        check_eq("restart_29", 32'(flashing_out), 1);
        frames(1);
        check_eq("restart_30", 32'(flashing_out), 0);

        // Out-of-range layer is ignored
        t_start = 1; t_flayer = 3'd7; step(); t_start = 0;
        check_eq("bad_layer7", 32'(flashing_out), 0);
        t_start = 1; t_flayer = 3'd6; step(); t_start = 0;
        check_eq("bad_layer6", 32'(flashing_out), 0);

        // Start and frame pulse together: frame not counted
        t_start = 1; t_nf = 1; t_flayer = 3'd5; step(); t_start = 0; t_nf = 0;
        step();
        frames(29);
        check_eq("same_clk_29", 32'(flashing_out), 1);
        frames(1);
        check_eq("same_clk_30", 32'(flashing_out), 0);

        // Random traffic with a mid-stream reset
        for (int c = 0; c < 10000; c++) begin
            randomize_inputs();
            if (c == 5000) do_reset();
            step();
        end
        t_start = 0; t_nf = 0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
